// File: rtl/nibble_deser_if.sv
// Handshake/serial bundle for nibble_deser: the receiver (slave) takes serial input,
// and the producer/consumer side (master) drives serial data and accepts nibbles.
interface nibble_deser_if;
    logic       sin;
    logic       sen;
    logic       q_ready;
    logic [0:3] q;
    logic       q_valid;
    logic       par_err;
    logic       ovr;
    logic       busy;

    modport master (
        output sin, sen, q_ready,
        input  q, q_valid, par_err, ovr, busy
    );

    modport slave (
        input  sin, sen, q_ready,
        output q, q_valid, par_err, ovr, busy
    );
endinterface

// File: rtl/nibble_deser.sv
// Serial-to-parallel nibble receiver: start bit, four data bits and an optional even-parity
// bit; the nibble is presented on a [0:3] register with valid/ready, parity and overrun status.
module nibble_deser #(
    parameter int unsigned PARITY      = 1,
    parameter bit          START_LEVEL = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    nibble_deser_if.slave  bus_io
);

    typedef enum logic [1:0] {StIdle, StData, StPar} state_e;

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [0:3] shift_q, shift_d;
    logic       complete;
    logic       par_bit;
    logic       new_perr;

    logic [0:3] q_q, q_d;
    logic       q_valid_q, q_valid_d;
    logic       par_err_q, par_err_d;
    logic       ovr_q, ovr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            shift_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        complete = 1'b0;
        par_bit  = 1'b0;
        if (bus_io.sen) begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.sin == START_LEVEL) begin
                        state_d = StData;
                        cnt_d   = 2'd0;
                    end
                end
                StData: begin
                    shift_d[cnt_q] = bus_io.sin;
                    cnt_d          = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (PARITY != 0) begin
                            state_d = StPar;
                        end else begin
                            state_d  = StIdle;
                            complete = 1'b1;
                        end
                    end
                end
                StPar: begin
                    par_bit  = bus_io.sin;
                    state_d  = StIdle;
                    complete = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // shift_d already holds the final data bit when completing straight from StData.
    always_comb begin
        new_perr  = (PARITY != 0) ? ((^shift_d) ^ par_bit) : 1'b0;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        par_err_d = par_err_q;
        ovr_d     = ovr_q;
        if (complete) begin
            if (!q_valid_q || bus_io.q_ready) begin
                q_d       = shift_d;
                par_err_d = new_perr;
                q_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (q_valid_q && bus_io.q_ready) begin
            q_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= 4'b0000;
            q_valid_q <= 1'b0;
            par_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            par_err_q <= par_err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus_io.q       = q_q;
    assign bus_io.q_valid = q_valid_q;
    assign bus_io.par_err = par_err_q;
    assign bus_io.ovr     = ovr_q;
    assign bus_io.busy    = (state_q != StIdle);

endmodule

// File: tb/tb_nibble_deser.sv
// Self-checking bench for nibble_deser (PARITY=1): directed scenarios plus randomized frames
// checked against a transaction-level reference model.
module tb_nibble_deser;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_deser_if bus ();

    nibble_deser #(
        .PARITY      (1),
        .START_LEVEL (1'b0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: state of the output register as seen by the consumer.
    logic [0:3] m_q;
    logic       m_valid, m_perr, m_ovr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.sen     = 1'b0;
        bus.sin     = 1'b1;
        bus.q_ready = 1'b0;
        rst         = 1'b1;
        step();
        step();
        rst     = 1'b0;
        m_q     = 4'b0000;
        m_valid = 1'b0;
        m_perr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bus.sen = 1'b1;
        bus.sin = b;
        step();
        bus.sen = 1'b0;
        bus.sin = 1'($urandom_range(0, 1));
        repeat (gap) step();
    endtask

    // Start, four data bits (nib[0] first), parity; q_ready is only raised on the final edge.
    task automatic send_frame(input logic [0:3] nib, input logic pbit, input int gap,
                              input logic rdy_last);
        bus.q_ready = 1'b0;
        send_bit(1'b0, gap);
        for (int i = 0; i < 4; i++) send_bit(nib[i], gap);
        bus.q_ready = rdy_last;
        bus.sen     = 1'b1;
        bus.sin     = pbit;
        step();
        bus.sen     = 1'b0;
        bus.q_ready = 1'b0;
    endtask

    task automatic accept();
        bus.q_ready = 1'b1;
        step();
        bus.q_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.sen     = 1'b0;
        bus.sin     = 1'b1;
        bus.q_ready = 1'b0;
        rst         = 1'b1;
        #2;
        checks++;
        if ({bus.q, bus.q_valid, bus.par_err, bus.ovr, bus.busy} !== 8'b0) begin
            failures++;
            $display("FAIL reset_outputs: got q=%b v=%b pe=%b ovr=%b busy=%b, want all 0",
                     bus.q, bus.q_valid, bus.par_err, bus.ovr, bus.busy);
        end
        do_reset();
    endtask

    task automatic test_basic();
        bus.q_ready = 1'b0;
        bus.sen = 1'b1; bus.sin = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_after_start: got %b want 1", bus.busy);
        end
        bus.sen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.sen = 1'b1;
            bus.sin = (i == 1) ? 1'b0 : 1'b1;
            step();
        end
        checks++;
        if (bus.q_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_valid_before_parity: got %b want 0", bus.q_valid);
        end
        bus.sin = 1'b1;
        step();
        bus.sen = 1'b0;
        checks++;
        if (bus.q !== 4'b1011 || bus.par_err !== 1'b0 || bus.q_valid !== 1'b1 ||
            bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_frame: got q=%b pe=%b v=%b busy=%b want q=1011 pe=0 v=1 busy=0",
                     bus.q, bus.par_err, bus.q_valid, bus.busy);
        end
        accept();
        checks++;
        if (bus.q_valid !== 1'b0 || bus.q !== 4'b1011) begin
            failures++;
            $display("FAIL basic_accept: got v=%b q=%b want v=0 q=1011", bus.q_valid, bus.q);
        end
    endtask

    task automatic test_parity_err();
        send_frame(4'b0001, 1'b0, 0, 1'b0);
        checks++;
        if (bus.q !== 4'b0001 || bus.par_err !== 1'b1 || bus.q_valid !== 1'b1) begin
            failures++;
            $display("FAIL parity_err: got q=%b pe=%b v=%b want q=0001 pe=1 v=1",
                     bus.q, bus.par_err, bus.q_valid);
        end
        accept();
    endtask

    task automatic test_sen_gaps();
        logic [0:5] bits;
        logic       busy_ok;
        bits    = 6'b010111;
        busy_ok = 1'b1;
        bus.q_ready = 1'b0;
        bus.sen = 1'b1; bus.sin = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL gaps_idle_ignored: got busy=%b want 0", bus.busy);
        end
        for (int i = 0; i < 6; i++) begin
            bus.sen = 1'b1;
            bus.sin = bits[i];
            step();
            bus.sen = 1'b0;
            bus.sin = ~bits[i];
            if (i < 5) begin
                for (int g = 0; g < 3; g++) begin
                    if (bus.busy !== 1'b1) busy_ok = 1'b0;
                    step();
                end
                if (bus.busy !== 1'b1) busy_ok = 1'b0;
            end
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            failures++;
            $display("FAIL gaps_busy_in_frame: got busy dropped=%b want 0", ~busy_ok);
        end
        checks++;
        if (bus.q !== 4'b1011 || bus.par_err !== 1'b0 || bus.q_valid !== 1'b1 ||
            bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL gaps_frame: got q=%b pe=%b v=%b busy=%b want q=1011 pe=0 v=1 busy=0",
                     bus.q, bus.par_err, bus.q_valid, bus.busy);
        end
        accept();
    endtask

    task automatic test_overrun();
        send_frame(4'b1011, 1'b1, 0, 1'b0);
        send_frame(4'b0110, 1'b0, 0, 1'b0);
        checks++;
        if (bus.q !== 4'b1011 || bus.ovr !== 1'b1 || bus.q_valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_hold: got q=%b ovr=%b v=%b want q=1011 ovr=1 v=1",
                     bus.q, bus.ovr, bus.q_valid);
        end
        accept();
        checks++;
        if (bus.q_valid !== 1'b0 || bus.ovr !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got v=%b ovr=%b want v=0 ovr=1", bus.q_valid, bus.ovr);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        send_frame(4'b1011, 1'b1, 0, 1'b0);
        send_frame(4'b0110, 1'b0, 0, 1'b1);
        checks++;
        if (bus.q !== 4'b0110 || bus.q_valid !== 1'b1 || bus.ovr !== 1'b0 ||
            bus.par_err !== 1'b0) begin
            failures++;
            $display("FAIL simul_accept_complete: got q=%b v=%b ovr=%b pe=%b want 0110 1 0 0",
                     bus.q, bus.q_valid, bus.ovr, bus.par_err);
        end
    endtask

    task automatic test_reset_mid();
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.q, bus.q_valid, bus.par_err, bus.ovr, bus.busy} !== 8'b0) begin
            failures++;
            $display("FAIL reset_mid_async: got q=%b v=%b pe=%b ovr=%b busy=%b want all 0",
                     bus.q, bus.q_valid, bus.par_err, bus.ovr, bus.busy);
        end
        do_reset();
        send_frame(4'b1100, 1'b0, 0, 1'b0);
        checks++;
        if (bus.q !== 4'b1100 || bus.par_err !== 1'b0 || bus.q_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_refill: got q=%b pe=%b v=%b want q=1100 pe=0 v=1",
                     bus.q, bus.par_err, bus.q_valid);
        end
    endtask

    task automatic test_random();
        logic [0:3] nib;
        logic       pbit, rdy;
        int         gap;
        int         bad;
        do_reset();
        bad = 0;
        for (int n = 0; n < 40; n++) begin
            nib  = 4'($urandom);
            pbit = 1'($urandom);
            rdy  = 1'($urandom);
            gap  = $urandom_range(0, 2);
            send_frame(nib, pbit, gap, rdy);
            if (!m_valid || rdy) begin
                m_q     = nib;
                m_perr  = (nib[0] + nib[1] + nib[2] + nib[3] + pbit) % 2 == 1;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            checks++;
            if (bus.q !== m_q || bus.q_valid !== m_valid || bus.par_err !== m_perr ||
                bus.ovr !== m_ovr || bus.busy !== 1'b0) begin
                failures++;
                bad++;
                $display("FAIL random_frame_%0d: got q=%b v=%b pe=%b ovr=%b busy=%b want %b %b %b %b 0",
                         n, bus.q, bus.q_valid, bus.par_err, bus.ovr, bus.busy,
                         m_q, m_valid, m_perr, m_ovr);
            end
            if ($urandom_range(0, 2) == 0) begin
                accept();
                m_valid = 1'b0;
                checks++;
                if (bus.q_valid !== 1'b0 || bus.q !== m_q) begin
                    failures++;
                    $display("FAIL random_accept_%0d: got v=%b q=%b want v=0 q=%b",
                             n, bus.q_valid, bus.q, m_q);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_err();
        test_sen_gaps();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_deser.md
# nibble_deser

Serial-to-parallel nibble receiver: the inbound end of the team's 4-bit lab datapath, which otherwise reduces 4-bit `[0:3]` vectors to single-bit outputs. It samples a framed serial stream (start bit, four data bits, optional even-parity bit) and presents the nibble on a `[0:3]` output register with a valid/ready handshake. Parity-error and overrun status travel with the data. It feeds the existing 4-bit consumer modules and their benches.

## Interface
- `PARITY`, default 1: 1 = even-parity bit follows the data; 0 = no parity bit.
- `START_LEVEL`, default 0: serial level that marks a start bit.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `sin`  in  1  serial data
- `sen`  in  1  bit qualifier; `sin` is sampled only on a `clk` rising edge with `sen`=1
- `q_ready`  in  1  consumer accepts `q`
- `q`  out  [0:3]  received nibble; `q[0]` is the first data bit received
- `q_valid`  out  1  `q` holds an unaccepted nibble
- `par_err`  out  1  parity status of `q`; meaningful only while `q_valid`=1
- `ovr`  out  1  sticky overrun flag
- `busy`  out  1  frame in progress (state ≠ IDLE)

## Operation
- Reset (async, immediate): state IDLE, bit counter 0, shift register 0, `q`=4'b0000, `q_valid`=0, `par_err`=0, `ovr`=0, `busy`=0. A partial frame is discarded.
- States: IDLE, DATA, PAR (PAR exists only when `PARITY`=1).
- IDLE: a qualified sample with `sin`==`START_LEVEL` moves to DATA with counter 0. Any other qualified sample is ignored.
- DATA: each qualified sample is stored as data bit `counter` (0 first), then the counter increments. After bit 3 the block goes to PAR if `PARITY`=1, otherwise it completes and returns to IDLE.
- PAR: one qualified sample is taken. The frame completes and the block returns to IDLE.
- Cycles with `sen`=0 hold all state. There is no timeout.
- Parity: `par_err` = XOR of the 4 data bits and the parity bit. With `PARITY`=0, `par_err` is always 0. A nibble with a parity error is still delivered.
- Completion (on the edge that samples the final bit):
  - If `q_valid`=0, or `q_valid`=1 and `q_ready`=1 on that edge: load `q` and `par_err`, and set `q_valid`=1.
  - If `q_valid`=1 and `q_ready`=0: discard the new nibble, set `ovr`=1, and leave `q`, `par_err` and `q_valid` unchanged.
- Accept: an edge with `q_valid`=1 and `q_ready`=1 and no completion clears `q_valid`. `q` and `par_err` keep their last values.
- `q_ready` while `q_valid`=0 has no effect.
- `ovr` clears only on `rst`.

## Timing
- All outputs are registered and change only on `clk` rising edges or `rst` assertion.
- A frame is 6 qualified samples with `PARITY`=1, 5 with `PARITY`=0.
- With `sen` held high, a start bit sampled at edge N gives `q_valid`=1 after edge N+5 (`PARITY`=1) or N+4 (`PARITY`=0).
- `busy` goes to 1 after the start-bit edge and to 0 after the completion edge.
- Back-to-back frames are allowed: the start bit may be sampled on the edge immediately after the completion edge.
- Accept takes effect at the edge where `q_ready`=1, so `q_valid` is low in the following cycle.
- Combinational paths: none from inputs to outputs.

## Test plan
- `PARITY`=1, `sen`=1 continuously. Serial stream 0 (start), 1, 0, 1, 1, parity 1. Expected: `q`=4'b1011, `par_err`=0, `q_valid`=1 after the 6th edge. Assert `q_ready` for one cycle and `q_valid` returns to 0 after that edge.
- Parity error: stream 0, 0, 0, 0, 1, parity 0. Expected: `q`=4'b0001, `par_err`=1, `q_valid`=1.
- `sen` gaps: repeat the first scenario with `sen`=0 for 3 cycles between each bit, and drive `sin`=1 in idle with `sen`=1 before the start bit. Expected: idle samples ignored, same `q`/`par_err` result, `busy`=1 from the start edge until the completion edge.
- Overrun: hold `q_ready`=0 and send frames 4'b1011 then 4'b0110. Expected: `q` stays 4'b1011 and `ovr`=1. Then `q_ready`=1 for one cycle: `q_valid` goes to 0 and `ovr` stays 1.
- Simultaneous accept and completion: `q_valid`=1 with `q`=4'b1011, and `q_ready`=1 exactly on the completion edge of frame 4'b0110. Expected: `q`=4'b0110, `q_valid` stays 1, `ovr`=0.
- Reset mid-frame: assert `rst` between clock edges after 2 data bits. Expected: all outputs 0 and `busy`=0 immediately, before the next edge. After release, a full frame 4'b1100 with parity 0 gives `q`=4'b1100 and `par_err`=0.
